// File: rtl/dbus_initiator.sv
// Data-bus master: 2-deep request FIFO, one access in flight, local error responses.
// Optional DBUS_ALIGN_CHECK_EN rejects misaligned addresses instead of masking addr[1:0].
module dbus_initiator #(
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] VALID = 32'h0000_0800,
  parameter logic [31:0] HEX   = 32'hF000_0000,
  parameter logic [31:0] LEDR  = 32'hF000_0004,
  parameter logic [31:0] LEDG  = 32'hF000_0008,
  parameter logic [31:0] KEY   = 32'hF000_0010,
  parameter logic [31:0] SW    = 32'hF000_0014
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] dbus_addr,
  output logic        dbus_wren,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_in
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // ISSUE plus the WAIT cycles must total READ_LATENCY address cycles.
  localparam logic [1:0] WAIT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

  state_t      state;
  logic [1:0]  wait_cnt;

  logic        wr_q    [2];
  logic [31:0] addr_q  [2];
  logic [31:0] wdata_q [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  logic        head_wr;
  logic [31:0] head_addr;
  logic [31:0] head_wdata;
  logic [31:0] bus_addr;
  logic        aligned;
  logic        legal;

  assign req_ready = (count != 2'd2);
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (count != 2'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      wr_q[wr_ptr]    <= req_wr;
      addr_q[wr_ptr]  <= req_addr;
      wdata_q[wr_ptr] <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head_wr    = wr_q[rd_ptr];
    head_addr  = addr_q[rd_ptr];
    head_wdata = wdata_q[rd_ptr];
`ifdef DBUS_ALIGN_CHECK_EN
    aligned  = (head_addr[1:0] == 2'b00);
    bus_addr = head_addr;
`else
    aligned  = 1'b1;
    bus_addr = head_addr & 32'hFFFF_FFFC;
`endif
    legal = 1'b0;
    if (aligned) begin
      if (bus_addr < VALID)
        legal = 1'b1;
      else if (head_wr)
        legal = (bus_addr == HEX) || (bus_addr == LEDR) || (bus_addr == LEDG);
      else
        legal = (bus_addr == KEY) || (bus_addr == SW);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 2'd0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      dbus_addr  <= '0;
      dbus_wren  <= 1'b0;
      dbus_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != 2'd0) begin
            if (legal) begin
              dbus_addr  <= bus_addr;
              dbus_wren  <= head_wr;
              dbus_wdata <= head_wr ? head_wdata : '0;
              state      <= ISSUE;
            end else begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        ISSUE: begin
          if (dbus_wren) begin
            dbus_wren  <= 1'b0;
            dbus_addr  <= '0;
            dbus_wdata <= '0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (READ_LATENCY == 1) begin
            rsp_rdata <= dbus_in;
            rsp_err   <= 1'b0;
            dbus_addr <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= WAIT_INIT;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            rsp_rdata <= dbus_in;
            rsp_err   <= 1'b0;
            dbus_addr <= '0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_initiator.sv
// Directed bench: u0 runs with READ_LATENCY=3 against a small memory model, u1 with READ_LATENCY=1.
module tb_dbus_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] dbus_addr, dbus_wdata, dbus_in;
  logic        dbus_wren;

  logic        req_valid1, req_ready1, req_wr1;
  logic [31:0] req_addr1, req_wdata1;
  logic        rsp_valid1, rsp_ready1, rsp_err1;
  logic [31:0] rsp_rdata1;
  logic [31:0] dbus_addr1, dbus_wdata1, dbus_in1;
  logic        dbus_wren1;

  logic [31:0] mem [256];
  logic [31:0] cyc = 32'd0;
  logic        cnt_mode;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_v;

  dbus_initiator #(.READ_LATENCY(3)) u0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dbus_addr(dbus_addr), .dbus_wren(dbus_wren), .dbus_wdata(dbus_wdata), .dbus_in(dbus_in)
  );

  dbus_initiator #(.READ_LATENCY(1)) u1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_wr(req_wr1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
    .dbus_addr(dbus_addr1), .dbus_wren(dbus_wren1), .dbus_wdata(dbus_wdata1), .dbus_in(dbus_in1)
  );

  always @(posedge clk) begin
    cyc <= cyc + 32'd1;
    if (dbus_wren) mem[dbus_addr[9:2]] <= dbus_wdata;
  end

  assign dbus_in  = cnt_mode ? cyc : mem[dbus_addr[9:2]];
  assign dbus_in1 = cyc ^ 32'hA5A5_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic take_rsp(input string tag, input logic [31:0] erd, input logic eerr);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, erd);
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, eerr});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    cnt_mode = 1'b0;
    reset = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    req_valid1 = 1'b0; req_wr1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; rsp_ready1 = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_dbus_addr", dbus_addr, 32'd0);
    chk("rst_dbus_wren", {31'd0, dbus_wren}, 32'd0);
    chk("rst_dbus_wdata", dbus_wdata, 32'd0);

    // single store, then load back through the 3-cycle read path
    push(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("st_e0_wren", {31'd0, dbus_wren}, 32'd0);
    tick();
    chk("st_e1_wren", {31'd0, dbus_wren}, 32'd1);
    chk("st_e1_addr", dbus_addr, 32'h0000_0010);
    chk("st_e1_wdata", dbus_wdata, 32'hDEAD_BEEF);
    chk("st_e1_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("st_e2_wren", {31'd0, dbus_wren}, 32'd0);
    chk("st_e2_addr", dbus_addr, 32'd0);
    take_rsp("st_rsp", 32'd0, 1'b0);
    chk("st_after_valid", {31'd0, rsp_valid}, 32'd0);

    push(1'b0, 32'h0000_0010, 32'd0);
    tick();
    chk("ld_e1_addr", dbus_addr, 32'h0000_0010);
    chk("ld_e1_wren", {31'd0, dbus_wren}, 32'd0);
    tick();
    chk("ld_e2_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("ld_e3_valid", {31'd0, rsp_valid}, 32'd0);
    chk("ld_e3_addr", dbus_addr, 32'h0000_0010);
    tick();
    chk("ld_e4_addr", dbus_addr, 32'd0);
    take_rsp("ld_rsp", 32'hDEAD_BEEF, 1'b0);

    // wrong-direction I/O accesses are rejected without a bus cycle
    push(1'b1, 32'hF000_0014, 32'h1234_5678);
    tick();
    chk("err_st_e1_valid", {31'd0, rsp_valid}, 32'd1);
    chk("err_st_e1_wren", {31'd0, dbus_wren}, 32'd0);
    take_rsp("err_st", 32'd0, 1'b1);
    push(1'b0, 32'hF000_0000, 32'd0);
    chk("err_ld_wren", {31'd0, dbus_wren}, 32'd0);
    take_rsp("err_ld", 32'd0, 1'b1);

    // backpressure: three requests with rsp_ready low
    push(1'b1, 32'h0000_0020, 32'h1111_1111);
    push(1'b0, 32'h0000_0010, 32'd0);
    push(1'b0, 32'h0000_0020, 32'd0);
    chk("bp_full_ready", {31'd0, req_ready}, 32'd0);
    take_rsp("bp_a", 32'd0, 1'b0);
    chk("bp_nobypass_ready", {31'd0, req_ready}, 32'd0);
    tick();
    chk("bp_popped_ready", {31'd0, req_ready}, 32'd1);
    take_rsp("bp_b", 32'hDEAD_BEEF, 1'b0);
    take_rsp("bp_c", 32'h1111_1111, 1'b0);

    // READ_LATENCY=3: data sampled from the third address cycle
    cnt_mode = 1'b1;
    push(1'b0, 32'h0000_0040, 32'd0);
    tick();
    tick();
    tick();
    exp_v = cyc;
    chk("rl3_valid_pre", {31'd0, rsp_valid}, 32'd0);
    tick();
    take_rsp("rl3", exp_v, 1'b0);
    cnt_mode = 1'b0;

    // READ_LATENCY=1 instance
    req_valid1 = 1'b1; req_wr1 = 1'b0; req_addr1 = 32'h0000_0040;
    tick();
    req_valid1 = 1'b0;
    tick();
    chk("rl1_e1_addr", dbus_addr1, 32'h0000_0040);
    chk("rl1_e1_valid", {31'd0, rsp_valid1}, 32'd0);
    exp_v = cyc ^ 32'hA5A5_0000;
    tick();
    chk("rl1_e2_valid", {31'd0, rsp_valid1}, 32'd1);
    chk("rl1_e2_rdata", rsp_rdata1, exp_v);
    chk("rl1_e2_addr", dbus_addr1, 32'd0);
    rsp_ready1 = 1'b1;
    tick();
    rsp_ready1 = 1'b0;
    chk("rl1_done_valid", {31'd0, rsp_valid1}, 32'd0);

    // reset while a load waits and a store is queued
    push(1'b0, 32'h0000_0010, 32'd0);
    push(1'b1, 32'h0000_0030, 32'h5555_AAAA);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_addr", dbus_addr, 32'd0);
    chk("mid_rst_wren", {31'd0, dbus_wren}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_rst_quiet_valid", {31'd0, rsp_valid}, 32'd0);
      chk("mid_rst_quiet_wren", {31'd0, dbus_wren}, 32'd0);
    end

    // misaligned store
    push(1'b1, 32'h0000_0012, 32'h1234_5678);
    tick();
`ifdef DBUS_ALIGN_CHECK_EN
    chk("align_wren", {31'd0, dbus_wren}, 32'd0);
    take_rsp("align", 32'd0, 1'b1);
`else
    chk("align_addr", dbus_addr, 32'h0000_0010);
    chk("align_wren", {31'd0, dbus_wren}, 32'd1);
    take_rsp("align", 32'd0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
